// File: rtl/mlaccel_pkg.sv
// Shared widths, port ids and helpers for the mlaccel memory path.
// Top, arbiter and memory all size their buses from these constants.
package mlaccel_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_WEN_W  = MEM_DATA_W / 8;

    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_COMP = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e id;
    } tag_t;

    typedef enum logic [1:0] {
        PEND_IDLE,
        PEND_WAIT,
        PEND_DONE
    } pend_e;

    // A port stays pending after done until its requester lets go,
    // so a request still held past done is never re-issued.
    function automatic pend_e pend_next(
        input pend_e s,
        input logic  grant,
        input logic  done,
        input logic  req
    );
        pend_e n;
        n = s;
        unique case (s)
            PEND_IDLE: if (grant) n = PEND_WAIT;
            PEND_WAIT: if (done)  n = PEND_DONE;
            PEND_DONE: if (!req)  n = PEND_IDLE;
            default:              n = PEND_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mlaccel_memarb_tagpipe.sv
// Fixed-latency tag pipeline: follows each grant through the memory
// and emits a one-cycle done pulse to the owning port.
module mlaccel_memarb_tagpipe
    import mlaccel_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  grant_valid,
    input  port_e grant_id,
    output logic  h_done,
    output logic  c_done
);

    tag_t pipe [MEM_LAT];
    tag_t last;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe[i] <= '{valid: 1'b0, id: PORT_HOST};
            end
        end else begin
            pipe[0] <= '{valid: grant_valid, id: grant_id};
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign last   = pipe[MEM_LAT-1];
    assign h_done = ~reset & last.valid & (last.id == PORT_HOST);
    assign c_done = ~reset & last.valid & (last.id == PORT_COMP);

endmodule

// File: rtl/mlaccel_memarb.sv
// Two-port (host / compute) arbiter in front of mlaccel_memory:
// one grant per cycle, fixed-latency completion back to the owner.
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                h_read,
    input  logic [DATA_W/8-1:0] h_wen,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    output logic                h_done,
    output logic [DATA_W-1:0]   h_rdata,
    input  logic                c_read,
    input  logic [DATA_W/8-1:0] c_wen,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    output logic                c_done,
    output logic [DATA_W-1:0]   c_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    pend_e h_state, h_next;
    pend_e c_state, c_next;
    port_e last_grant;

    logic  h_req, c_req;
    logic  h_elig, c_elig;
    logic  h_grant, c_grant;
    logic  grant;
    port_e grant_id;

    assign h_req  = h_read | (|h_wen);
    assign c_req  = c_read | (|c_wen);
    assign h_elig = ~reset & h_req & (h_state == PEND_IDLE);
    assign c_elig = ~reset & c_req & (c_state == PEND_IDLE);

    assign h_grant  = h_elig & (~c_elig | (last_grant == PORT_COMP));
    assign c_grant  = c_elig & ~h_grant;
    assign grant    = h_grant | c_grant;
    assign grant_id = h_grant ? PORT_HOST : PORT_COMP;

    always_comb begin
        mem_addr  = '0;
        mem_wen   = '0;
        mem_wdata = '0;
        unique case (1'b1)
            h_grant: begin
                mem_addr  = h_addr;
                mem_wen   = h_wen;
                mem_wdata = h_wdata;
            end
            c_grant: begin
                mem_addr  = c_addr;
                mem_wen   = c_wen;
                mem_wdata = c_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        h_next = pend_next(h_state, h_grant, h_done, h_req);
        c_next = pend_next(c_state, c_grant, c_done, c_req);
    end

    // Priority only moves on contended cycles, so ties alternate
    // regardless of how many uncontested grants happen in between.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_state    <= PEND_IDLE;
            c_state    <= PEND_IDLE;
            last_grant <= PORT_COMP;
        end else begin
            h_state <= h_next;
            c_state <= c_next;
            if (h_elig && c_elig) begin
                last_grant <= grant_id;
            end
        end
    end

    mlaccel_memarb_tagpipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tagpipe (
        .clock       (clock),
        .reset       (reset),
        .grant_valid (grant),
        .grant_id    (grant_id),
        .h_done      (h_done),
        .c_done      (c_done)
    );

    assign h_rdata = mem_rdata;
    assign c_rdata = mem_rdata;

    assign busy = ~reset & ((h_state != PEND_IDLE) |
                            (c_state != PEND_IDLE) |
                            h_elig | c_elig);

endmodule
